lsu_hs_gen2: RTL
================

// Module: lsu_hs_gen2
// PURPOSE
//  Second-generation load/store unit with a valid/ready request port from the core and
//  a req/ack port to a multi-cycle data memory (SRAM controller).
//  Decodes three address windows: data memory, output peripherals, input peripherals.
//  Performs byte-lane steering, sign/zero extension, misalignment and unmapped-access
//  detection, and a bounded-latency timeout.
//  Sits between the core's MEM stage and the memory/peripheral fabric.
// PARAMETERS
//  AW          16      decoded address width (i_addr[AW-1:0])
//  DMEM_BASE   'h2000  first byte address of data memory window
//  DMEM_LAST   'h3FFF  last byte address of data memory window
//  OPER_BASE   'h7000  output-peripheral window base
//  OPER_LAST   'h703F  output-peripheral window last
//  IPER_BASE   'h7800  input-peripheral window base
//  IPER_LAST   'h781F  input-peripheral window last
//  TIMEOUT     255     max cycles waiting for i_mem_ack before fault (>=1)
// PORTS
//  i_clk          in   1   clock, rising edge
//  i_rst          in   1   synchronous reset, active-high
//  i_req_valid    in   1   core request valid
//  o_req_ready    out  1   LSU can accept request (IDLE only)
//  i_addr         in   32  byte address
//  i_wren         in   1   1=store, 0=load
//  i_lsu_op       in   3   000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
//  i_st_data      in   32  store data, LSB-justified
//  o_rsp_valid    out  1   one-cycle response strobe
//  o_ld_data      out  32  extended load result (0 for stores/faults)
//  o_fault        out  2   00 ok, 01 misaligned/illegal op, 10 unmapped, 11 timeout
//  o_busy         out  1   state != IDLE (core stall)
//  o_mem_req      out  1   data-memory request, held until ack
//  o_mem_we       out  1   data-memory write
//  o_mem_addr     out  AW  word address relative to DMEM_BASE, low 2 bits zero
//  o_mem_bmask    out  4   byte-lane enables
//  o_mem_wdata    out  32  lane-steered store data
//  i_mem_ack      in   1   data-memory completion
//  i_mem_rdata    in   32  data-memory read word (valid with ack)
//  o_per_we       out  1   output-peripheral write strobe (1 cycle)
//  o_per_addr     out  AW  peripheral word address; o_per_bmask/o_per_wdata as mem
//  i_oper_rdata   in   32  output-peripheral readback word
//  i_iper_rdata   in   32  input-peripheral word
// BEHAVIOUR
//  Reset: state IDLE, o_req_ready=1, all other outputs 0, timeout counter 0.
//  Accept on i_req_valid&o_req_ready; addr/op/data/wren registered (request cycle N).
//  Checks in IDLE at accept: H/HU with addr[0]=1, W with addr[1:0]!=0, or illegal op
//    -> fault 01. Else address outside all windows -> fault 10.
//    On either fault: no memory/peripheral access; state ERR; rsp at N+1.
//  Lanes: off=addr[1:0]. B mask 0001<<off, H mask 0011<<off, W 1111.
//    wdata = st_data replicated per lane (B x4, H x2).
//    Load: extract lane at off, then sign-extend (B,H) or zero-extend (BU,HU).
//  FSM: IDLE -> MEM_WAIT (dmem hit) | PER (peripheral hit) | ERR (fault).
//    PER: o_per_we=i_wren for 1 cycle at N+1; read sampled at N+1;
//         rsp_valid at N+1; -> IDLE.
//    MEM_WAIT: o_mem_req=1 from N+1, outputs stable until i_mem_ack.
//      On ack: capture rdata, drop req, rsp_valid next cycle -> RESP -> IDLE.
//      Ack in first MEM_WAIT cycle gives rsp at N+2.
//      Counter increments each wait cycle; at TIMEOUT without ack:
//        drop req, fault 11, rsp next cycle, -> IDLE.
//    ERR: rsp_valid=1, o_ld_data=0 -> IDLE.
//  Stores: rsp_valid still pulses, o_ld_data=0.
//  i_mem_ack outside MEM_WAIT is ignored.
//  o_busy=1 in every non-IDLE state; no new request accepted until back in IDLE
//    (back-to-back minimum 2 cycles/request).
//  Reset mid-transaction: abandon, o_mem_req drops in the reset cycle, no rsp issued.
// TESTING
//  LW 0x2004, ack after 3 cycles with rdata 0xDEADBEEF
//    -> mem_addr 0x0004, bmask 1111, rsp N+5, ld_data 0xDEADBEEF, fault 00.
//  LB 0x2003, rdata 0x80xxxxxx -> bmask 1000, ld_data 0xFFFFFF80;
//    LBU same -> 0x00000080.
//  SH 0x7002 data 0x1234 -> per_we 1 cycle, bmask 1100, wdata 0x12341234,
//    rsp N+1, no o_mem_req.
//  LW 0x2002 -> fault 01; LW 0x5000 -> fault 10; neither asserts mem_req/per_we.
//  No ack for TIMEOUT=4 -> req high 4 cycles, then fault 11, ld_data 0, busy clears.
//  Assert i_rst during MEM_WAIT -> next cycle req 0, ready 1, no rsp_valid.

Source files
------------

// File: rtl/lsu_hs_gen2.sv
// lsu_hs_gen2 - load/store unit between the core MEM stage and the memory/peripheral fabric.
//
// Takes one request at a time from the core over a valid/ready port. The low AW address bits
// are decoded into three windows: data memory (multi-cycle SRAM controller, req/ack),
// output peripherals and input peripherals (both single-cycle). The unit steers byte lanes,
// sign- or zero-extends loads, and reports misaligned/illegal, unmapped and timeout faults.
//
// Ports
//   i_clk, i_rst                 clock (rising edge), synchronous active-high reset
//   i_req_valid / o_req_ready    core request handshake; i_addr, i_wren, i_lsu_op, i_st_data
//   o_rsp_valid                  one-cycle response strobe with o_ld_data and o_fault
//   o_busy                       high whenever the unit is not idle (core stall)
//   o_mem_*, i_mem_ack/rdata     data-memory port; the request is held until ack
//   o_per_*, i_oper/iper_rdata   peripheral port; write strobe lasts one cycle
//   o_dbg_state                  current FSM state, for debug and checkers
//
// Handshake: the core request transfers on a rising edge where i_req_valid && o_req_ready.
// o_req_ready is high only in IDLE and does not depend on i_req_valid. Toward data memory,
// o_mem_req rises in the cycle after accept and stays high, with address, mask and data
// stable, until the cycle in which i_mem_ack is sampled high. i_mem_ack seen outside that
// wait is ignored.
module lsu_hs_gen2 #(
    parameter int AW        = 16,
    parameter int DMEM_BASE = 'h2000,
    parameter int DMEM_LAST = 'h3FFF,
    parameter int OPER_BASE = 'h7000,
    parameter int OPER_LAST = 'h703F,
    parameter int IPER_BASE = 'h7800,
    parameter int IPER_LAST = 'h781F,
    parameter int TIMEOUT   = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [31:0]   i_addr,
    input  logic          i_wren,
    input  logic [2:0]    i_lsu_op,
    input  logic [31:0]   i_st_data,
    output logic          o_rsp_valid,
    output logic [31:0]   o_ld_data,
    output logic [1:0]    o_fault,
    output logic          o_busy,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [3:0]    o_mem_bmask,
    output logic [31:0]   o_mem_wdata,
    input  logic          i_mem_ack,
    input  logic [31:0]   i_mem_rdata,
    output logic          o_per_we,
    output logic [AW-1:0] o_per_addr,
    output logic [3:0]    o_per_bmask,
    output logic [31:0]   o_per_wdata,
    input  logic [31:0]   i_oper_rdata,
    input  logic [31:0]   i_iper_rdata,
    output logic [2:0]    o_dbg_state
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [AW-1:0] DM_LO = AW'(DMEM_BASE);
    localparam logic [AW-1:0] DM_HI = AW'(DMEM_LAST);
    localparam logic [AW-1:0] OP_LO = AW'(OPER_BASE);
    localparam logic [AW-1:0] OP_HI = AW'(OPER_LAST);
    localparam logic [AW-1:0] IP_LO = AW'(IPER_BASE);
    localparam logic [AW-1:0] IP_HI = AW'(IPER_LAST);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MEM_WAIT = 3'd1,
        S_PER      = 3'd2,
        S_RESP     = 3'd3,
        S_ERR      = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wren_q, wren_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   sdata_q, sdata_d;
    logic [1:0]    fault_q, fault_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          iper_q, iper_d;

    // Request decode, evaluated on the live inputs in the accept cycle.
    logic [AW-1:0] addr_lo;
    logic          op_legal, misaligned, hit_dmem, hit_oper, hit_iper;

    assign addr_lo  = i_addr[AW-1:0];
    assign op_legal = (i_lsu_op == 3'b000) || (i_lsu_op == 3'b001) || (i_lsu_op == 3'b010) ||
                      (i_lsu_op == 3'b100) || (i_lsu_op == 3'b101);
    assign misaligned = ((i_lsu_op[1:0] == 2'b01) && i_addr[0]) ||
                        ((i_lsu_op[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    assign hit_dmem = (addr_lo >= DM_LO) && (addr_lo <= DM_HI);
    assign hit_oper = (addr_lo >= OP_LO) && (addr_lo <= OP_HI);
    assign hit_iper = (addr_lo >= IP_LO) && (addr_lo <= IP_HI);

    // Only the low AW address bits take part in decode; upper bits alias.
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_addr[31:AW];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wren_q  <= 1'b0;
            op_q    <= '0;
            sdata_q <= '0;
            fault_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            iper_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wren_q  <= wren_d;
            op_q    <= op_d;
            sdata_q <= sdata_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            iper_q  <= iper_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wren_d  = wren_q;
        op_d    = op_q;
        sdata_d = sdata_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        iper_d  = iper_q;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    addr_d  = addr_lo;
                    wren_d  = i_wren;
                    op_d    = i_lsu_op;
                    sdata_d = i_st_data;
                    cnt_d   = '0;
                    rdata_d = '0;
                    iper_d  = hit_iper;
                    // Alignment/opcode faults take precedence over unmapped addresses.
                    if (!op_legal || misaligned) begin
                        fault_d = 2'b01;
                        state_d = S_ERR;
                    end else if (!(hit_dmem || hit_oper || hit_iper)) begin
                        fault_d = 2'b10;
                        state_d = S_ERR;
                    end else begin
                        fault_d = 2'b00;
                        state_d = hit_dmem ? S_MEM_WAIT : S_PER;
                    end
                end
            end
            S_MEM_WAIT: begin
                if (i_mem_ack) begin
                    rdata_d = i_mem_rdata;
                    state_d = S_RESP;
                end else if (cnt_q == TO_LAST) begin
                    // The request has now been held for TIMEOUT cycles with no ack.
                    fault_d = 2'b11;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PER, S_RESP, S_ERR: state_d = S_IDLE;
            default:              state_d = S_IDLE;
        endcase
    end

    // Lane steering, computed from the registered request.
    logic [1:0]    off;
    logic [3:0]    bmask;
    logic [31:0]   wdata;
    logic [AW-1:0] dm_rel;
    logic          unused_dm_rel;

    assign off           = addr_q[1:0];
    assign dm_rel        = addr_q - DM_LO;
    assign unused_dm_rel = ^dm_rel[1:0];

    always_comb begin
        case (op_q[1:0])
            2'b00:   begin bmask = 4'b0001 << off; wdata = {4{sdata_q[7:0]}};  end
            2'b01:   begin bmask = 4'b0011 << off; wdata = {2{sdata_q[15:0]}}; end
            default: begin bmask = 4'b1111;        wdata = sdata_q;            end
        endcase
    end

    function automatic logic [31:0] extend(input logic [31:0] word, input logic [2:0] op,
                                           input logic [1:0] lane_off);
        logic [31:0] lane;
        lane = word >> {lane_off, 3'b000};
        case (op)
            3'b000:  extend = {{24{lane[7]}}, lane[7:0]};
            3'b001:  extend = {{16{lane[15]}}, lane[15:0]};
            3'b100:  extend = {24'd0, lane[7:0]};
            3'b101:  extend = {16'd0, lane[15:0]};
            default: extend = lane;
        endcase
    endfunction

    // Strobes are gated with i_rst so an abandoned transaction goes quiet in the reset cycle.
    logic        in_mem, in_per, in_rsp;
    logic [31:0] ld_src;

    assign in_mem = (state_q == S_MEM_WAIT) && !i_rst;
    assign in_per = (state_q == S_PER) && !i_rst;
    assign in_rsp = ((state_q == S_PER) || (state_q == S_RESP) || (state_q == S_ERR)) && !i_rst;
    assign ld_src = (state_q == S_PER) ? (iper_q ? i_iper_rdata : i_oper_rdata) : rdata_q;

    assign o_req_ready = (state_q == S_IDLE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_dbg_state = state_q;

    assign o_mem_req   = in_mem;
    assign o_mem_we    = in_mem && wren_q;
    assign o_mem_addr  = in_mem ? {dm_rel[AW-1:2], 2'b00} : '0;
    assign o_mem_bmask = in_mem ? bmask : 4'b0000;
    assign o_mem_wdata = in_mem ? wdata : 32'd0;

    // The input-peripheral window is read-only, so stores never strobe it.
    assign o_per_we    = in_per && wren_q && !iper_q;
    assign o_per_addr  = in_per ? {addr_q[AW-1:2], 2'b00} : '0;
    assign o_per_bmask = in_per ? bmask : 4'b0000;
    assign o_per_wdata = in_per ? wdata : 32'd0;

    assign o_rsp_valid = in_rsp;
    assign o_fault     = in_rsp ? fault_q : 2'b00;
    assign o_ld_data   = (in_rsp && !wren_q && (fault_q == 2'b00)) ?
                         extend(ld_src, op_q, off) : 32'd0;

endmodule
